// File: rtl/xg_block_sync.sv
// 10GBASE-R block synchroniser: header lock FSM, gearbox slip, BER monitor.
// Ports: clk, rst_n, rx_header_valid/rx_header in; rx_bitslip, block_lock, hi_ber, lock_loss_count out; clear_stats in.
module xg_block_sync #(
  parameter int SH_WINDOW     = 64,
  parameter int INVALID_LIMIT = 16,
  parameter int SLIP_SETTLE   = 32,
  parameter int BER_WINDOW    = 40283,
  parameter int BER_LIMIT     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_header_valid,
  input  logic [1:0]  rx_header,
  output logic        rx_bitslip,
  output logic        block_lock,
  output logic        hi_ber,
  output logic [15:0] lock_loss_count,
  input  logic        clear_stats
);

  typedef enum logic [1:0] {
    HUNT,
    SLIP,
    LOCKED
  } state_t;

  localparam logic [6:0]  SH_LAST  = 7'(SH_WINDOW - 1);
  localparam logic [4:0]  INV_LAST = 5'(INVALID_LIMIT - 1);
  localparam logic [5:0]  SET_LAST = 6'(SLIP_SETTLE - 1);
  localparam logic [15:0] BER_LAST = 16'(BER_WINDOW - 1);
  localparam logic [4:0]  BER_LIM  = 5'(BER_LIMIT);
  localparam logic [4:0]  BER_PRE  = 5'(BER_LIMIT - 1);

  state_t      state, state_n;
  logic [6:0]  sh_cnt, sh_n;
  logic [4:0]  inv_cnt, inv_n;
  logic [5:0]  settle, settle_n;
  logic [15:0] ber_tmr;
  logic [4:0]  ber_cnt;
  logic        slip_n, lock_n, loss;
  logic        sh_ok, sh_bad;

  assign sh_ok  = rx_header_valid
                & (rx_header[1] ^ rx_header[0]);
  assign sh_bad = rx_header_valid
                & ~(rx_header[1] ^ rx_header[0]);

  always_comb begin
    state_n  = state;
    sh_n     = sh_cnt;
    inv_n    = inv_cnt;
    settle_n = settle;
    slip_n   = 1'b0;
    lock_n   = block_lock;
    loss     = 1'b0;
    unique case (state)
      HUNT: begin
        if (sh_bad) begin
          state_n  = SLIP;
          slip_n   = 1'b1;
          sh_n     = '0;
          settle_n = '0;
        end else if (sh_ok) begin
          if (sh_cnt == SH_LAST) begin
            state_n = LOCKED;
            lock_n  = 1'b1;
            sh_n    = '0;
            inv_n   = '0;
          end else begin
            sh_n = sh_cnt + 7'd1;
          end
        end
      end
      SLIP: begin
        // pulse cycle is settle==0; headers ignored throughout
        if (settle == SET_LAST) begin
          state_n  = HUNT;
          sh_n     = '0;
          inv_n    = '0;
          settle_n = '0;
        end else begin
          settle_n = settle + 6'd1;
        end
      end
      LOCKED: begin
        if (rx_header_valid) begin
          // loss of lock beats window restart
          if (sh_bad && inv_cnt == INV_LAST) begin
            state_n  = SLIP;
            lock_n   = 1'b0;
            slip_n   = 1'b1;
            loss     = 1'b1;
            sh_n     = '0;
            inv_n    = '0;
            settle_n = '0;
          end else if (sh_cnt == SH_LAST) begin
            sh_n  = '0;
            inv_n = '0;
          end else begin
            sh_n  = sh_cnt + 7'd1;
            inv_n = inv_cnt + {4'd0, sh_bad};
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      sh_cnt     <= '0;
      inv_cnt    <= '0;
      settle     <= '0;
      rx_bitslip <= 1'b0;
      block_lock <= 1'b0;
    end else begin
      state      <= state_n;
      sh_cnt     <= sh_n;
      inv_cnt    <= inv_n;
      settle     <= settle_n;
      rx_bitslip <= slip_n;
      block_lock <= lock_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_count <= '0;
    end else if (clear_stats) begin
      lock_loss_count <= '0;
    end else if (loss && lock_loss_count != 16'hFFFF) begin
      lock_loss_count <= lock_loss_count + 16'd1;
    end
  end

  // BER monitor only runs while lock holds now and next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ber_tmr <= '0;
      ber_cnt <= '0;
      hi_ber  <= 1'b0;
    end else if (!block_lock || !lock_n) begin
      ber_tmr <= '0;
      ber_cnt <= '0;
      hi_ber  <= 1'b0;
    end else if (ber_tmr == BER_LAST) begin
      ber_tmr <= '0;
      if (ber_cnt < BER_LIM) hi_ber <= 1'b0;
      ber_cnt <= {4'd0, sh_bad};
    end else begin
      ber_tmr <= ber_tmr + 16'd1;
      if (sh_bad) begin
        if (ber_cnt == BER_PRE) hi_ber <= 1'b1;
        if (ber_cnt != 5'h1F) ber_cnt <= ber_cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_xg_block_sync.sv
// Randomised scoreboard bench for xg_block_sync.
// Model predicts outputs per edge; monitor pops and compares.
module tb_xg_block_sync;

  localparam int BW = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v = 1'b0;
  logic [1:0]  h = 2'b00;
  logic        clr = 1'b0;
  logic        slip, lock, hb;
  logic [15:0] llc;

  always #5 clk = ~clk;

  xg_block_sync #(.BER_WINDOW(BW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_header_valid(v),
    .rx_header(h),
    .rx_bitslip(slip),
    .block_lock(lock),
    .hi_ber(hb),
    .lock_loss_count(llc),
    .clear_stats(clr)
  );

  typedef struct packed {
    logic        slip;
    logic        lock;
    logic        hb;
    logic [15:0] llc;
  } obs_t;

  obs_t q[$];
  int tests = 0;
  int fails = 0;

  bit m_lock, m_slip, m_hb;
  int settle_left, run, win, winbad;
  int age, berbad, losses;

  task automatic model_reset();
    m_lock = 0; m_slip = 0; m_hb = 0;
    settle_left = 0; run = 0;
    win = 0; winbad = 0;
    age = 0; berbad = 0; losses = 0;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    bit ok, bad, was;
    if (!rst_n) begin
      model_reset();
    end else begin
      ok = v && (h == 2'b01 || h == 2'b10);
      bad = v && !ok;
      was = m_lock;
      m_slip = 0;
      if (settle_left > 0) begin
        settle_left--;
      end else if (!m_lock) begin
        if (bad) begin
          m_slip = 1; settle_left = 32; run = 0;
        end else if (ok) begin
          run++;
          if (run == 64) begin
            m_lock = 1; run = 0; win = 0; winbad = 0;
          end
        end
      end else if (v) begin
        win++;
        if (bad) winbad++;
        if (winbad == 16) begin
          m_lock = 0; m_slip = 1; settle_left = 32;
          win = 0; winbad = 0;
          if (losses < 65535) losses++;
        end else if (win == 64) begin
          win = 0; winbad = 0;
        end
      end
      if (clr) losses = 0;
      if (!was || !m_lock) begin
        age = 0; berbad = 0; m_hb = 0;
      end else if (age == BW - 1) begin
        age = 0;
        if (berbad < 16) m_hb = 0;
        berbad = bad ? 1 : 0;
      end else begin
        age++;
        if (bad) begin
          if (berbad == 15) m_hb = 1;
          if (berbad < 31) berbad++;
        end
      end
    end
    q.push_back({m_slip, m_lock, m_hb, 16'(losses)});
  end

  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      a = {slip, lock, hb, llc};
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_empty t=%0t got=%h", $time, a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL cycle t=%0t slip=%b/%b lock=%b/%b hb=%b/%b cnt=%h/%h (got/exp)",
                   $time, a.slip, e.slip, a.lock, e.lock,
                   a.hb, e.hb, a.llc, e.llc);
        end
      end
    end
  end

  task automatic hdr(input logic vv, input logic [1:0] hh,
                     input logic cc = 1'b0);
    @(negedge clk);
    v = vv; h = hh; clr = cc;
  endtask

  function automatic logic [1:0] good_h();
    return $urandom_range(0, 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_h();
    return $urandom_range(0, 1) ? 2'b00 : 2'b11;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) hdr(1'b0, $urandom_range(0, 3));
  endtask

  task automatic relock();
    idle(40);
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      hdr(1'b1, good_h());
    end
    idle(2);
  endtask

  // 64-header window with nbad invalid headers at random positions
  task automatic window(input int nbad, input bit lastbad,
                        input bit clr_last = 0);
    bit pos[64];
    int lim, j;
    bit tb_;
    for (int i = 0; i < 64; i++) pos[i] = 0;
    lim = lastbad ? 63 : 64;
    for (int i = 0; i < nbad - (lastbad ? 1 : 0); i++) pos[i] = 1;
    for (int i = 0; i < lim; i++) begin
      j = $urandom_range(0, lim - 1);
      tb_ = pos[i]; pos[i] = pos[j]; pos[j] = tb_;
    end
    if (lastbad) pos[63] = 1;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      hdr(1'b1, pos[i] ? bad_h() : good_h(),
          clr_last && i == 63);
    end
    clr = 1'b0;
  endtask

  task automatic lose(input bit clr_on_loss);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1)) hdr(1'b1, good_h());
      hdr(1'b1, bad_h(), clr_on_loss && i == 15);
    end
    hdr(1'b0, 2'b00);
  endtask

  initial begin
    #1;
    tests++;
    if ({slip, lock, hb, llc} !== 19'd0) begin
      fails++;
      $display("FAIL reset_state got=%h exp=0", {slip, lock, hb, llc});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // lock with headers every other cycle
    for (int i = 0; i < 64; i++) begin
      hdr(1'b1, 2'b01);
      hdr(1'b0, $urandom_range(0, 3));
    end
    idle(3);

    // 15 bad tolerated, then 16 in a window loses lock
    window(15, 0);
    window(16, 0);
    idle(40);

    // slip in HUNT after 10 headers; settle headers ignored
    for (int i = 0; i < 10; i++) hdr(1'b1, good_h());
    hdr(1'b1, 2'b11);
    for (int i = 0; i < 31; i++)
      hdr(1'b1, $urandom_range(0, 3));
    relock();

    // 16th bad is also the 64th header
    window(16, 1);
    relock();

    // hi_ber from bad spread across header windows
    for (int w = 0; w < 3; w++) window(6, 0);
    for (int i = 0; i < 2 * BW + 50; i++)
      hdr($urandom_range(0, 1), good_h());

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0)
        hdr(1'b1, bad_h(), $urandom_range(0, 63) == 0);
      else
        hdr($urandom_range(0, 3) != 0, good_h(),
            $urandom_range(0, 255) == 0);
    end
    clr = 1'b0;
    relock();

    // saturation from a preloaded count
    @(negedge clk);
    force dut.lock_loss_count = 16'hFFFE;
    losses = 16'hFFFE;
    #1 release dut.lock_loss_count;
    lose(0);
    relock();
    lose(0);
    relock();
    lose(1);
    relock();
    lose(0);
    idle(3);
    hdr(1'b0, 2'b00, 1'b1);
    hdr(1'b0, 2'b00, 1'b0);
    relock();

    // async reset during the slip pulse
    lose(0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({slip, lock, hb, llc} !== 19'd0) begin
      fails++;
      $display("FAIL async_reset got=%h exp=0", {slip, lock, hb, llc});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    relock();
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
